// File: rtl/fp_unpack_pipe_if.sv
// Handshake bundle for fp_unpack_pipe: packed input word stream and unpacked field stream.
// The master modport is the producer/consumer side, the slave modport is the unpacker.
interface fp_unpack_pipe_if #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned FRAC_W = 12
);
    logic                      in_valid;
    logic                      in_ready;
    logic [EXP_W+FRAC_W:0]     in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic                      out_sign;
    logic [EXP_W:0]            out_exp;
    logic [FRAC_W:0]           out_frac;
    logic                      out_is_zero;
    logic                      out_is_inf;
    logic                      out_is_nan;
    logic                      out_is_denorm;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_frac,
               out_is_zero, out_is_inf, out_is_nan, out_is_denorm
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_frac,
               out_is_zero, out_is_inf, out_is_nan, out_is_denorm
    );
endinterface

// File: rtl/fp_unpack_pipe.sv
// Registered floating-point unpacker (default FP21 = 1+8+12) with a single valid/ready stage.
// Define FP_UNPACK_DENORM_EN to unpack denormals; otherwise they are flushed to signed zero.
module fp_unpack_pipe #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned FRAC_W = 12,
    parameter int unsigned BIAS   = (1 << (EXP_W - 1)) - 1
) (
    input  logic               clk,
    input  logic               rst,
    fp_unpack_pipe_if.slave    bus
);
    localparam logic [EXP_W:0] BIAS_V  = (EXP_W + 1)'(BIAS);
    localparam logic [EXP_W:0] EXP_MIN = (EXP_W + 1)'(1) - BIAS_V;

    logic              w_push;
    logic [EXP_W-1:0]  w_e;
    logic [FRAC_W-1:0] w_f;
    logic              w_sign;
    logic [EXP_W:0]    w_exp;
    logic [FRAC_W:0]   w_frac;
    logic              w_zero;
    logic              w_inf;
    logic              w_nan;
    logic              w_denorm;

    logic              r_valid;
    logic              r_sign;
    logic [EXP_W:0]    r_exp;
    logic [FRAC_W:0]   r_frac;
    logic              r_zero;
    logic              r_inf;
    logic              r_nan;
    logic              r_denorm;

    // One output register: accept whenever it is empty or being drained this cycle.
    assign bus.in_ready = !rst && (!r_valid || bus.out_ready);
    assign w_push       = bus.in_valid && bus.in_ready;

    assign w_e    = bus.in_data[EXP_W+FRAC_W-1 -: EXP_W];
    assign w_f    = bus.in_data[FRAC_W-1:0];
    assign w_sign = bus.in_data[EXP_W+FRAC_W];

    always_comb begin
        w_exp    = {1'b0, w_e} - BIAS_V;
        w_frac   = {1'b1, w_f};
        w_zero   = 1'b0;
        w_inf    = 1'b0;
        w_nan    = 1'b0;
        w_denorm = 1'b0;
        if (w_e == '0) begin
            w_exp = EXP_MIN;
            if (w_f == '0) begin
                w_frac = '0;
                w_zero = 1'b1;
            end else begin
`ifdef FP_UNPACK_DENORM_EN
                w_frac   = {1'b0, w_f};
                w_denorm = 1'b1;
`else
                w_frac = '0;
                w_zero = 1'b1;
`endif
            end
        end else if (&w_e) begin
            w_inf = (w_f == '0);
            w_nan = (w_f != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_sign   <= 1'b0;
            r_exp    <= '0;
            r_frac   <= '0;
            r_zero   <= 1'b0;
            r_inf    <= 1'b0;
            r_nan    <= 1'b0;
            r_denorm <= 1'b0;
        end else if (w_push) begin
            r_valid  <= 1'b1;
            r_sign   <= w_sign;
            r_exp    <= w_exp;
            r_frac   <= w_frac;
            r_zero   <= w_zero;
            r_inf    <= w_inf;
            r_nan    <= w_nan;
            r_denorm <= w_denorm;
        end else if (bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.out_valid     = r_valid;
    assign bus.out_sign      = r_sign;
    assign bus.out_exp       = r_exp;
    assign bus.out_frac      = r_frac;
    assign bus.out_is_zero   = r_zero;
    assign bus.out_is_inf    = r_inf;
    assign bus.out_is_nan    = r_nan;
    assign bus.out_is_denorm = r_denorm;
endmodule

// File: tb/tb_fp_unpack_pipe.sv
// Directed self-checking bench for fp_unpack_pipe at the default FP21 geometry.
// Denormal expectations follow FP_UNPACK_DENORM_EN when it is defined for the build.
module tb_fp_unpack_pipe;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    fp_unpack_pipe_if #(.EXP_W(8), .FRAC_W(12)) bus ();

    fp_unpack_pipe #(.EXP_W(8), .FRAC_W(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [20:0] din;
        logic        s;
        logic [8:0]  e;
        logic [12:0] f;
        logic [3:0]  fl;   // {zero, inf, nan, denorm}
    } vec_t;

    function automatic logic [20:0] mk_word(int k);
        return {1'b0, 8'(100 + k), 12'(k * 3 + 1)};
    endfunction

    function automatic logic [3:0] flags();
        return {bus.out_is_zero, bus.out_is_inf, bus.out_is_nan, bus.out_is_denorm};
    endfunction

    task automatic test_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 21'h07F000;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hs cyc%0d: out_valid=%b in_ready=%b, want 0 0", i, bus.out_valid, bus.in_ready);
            end
            n_checks++;
            if ({bus.out_sign, bus.out_exp, bus.out_frac, flags()} !== '0) begin
                n_fail++;
                $display("FAIL reset_fields cyc%0d: sign=%b exp=%h frac=%h flags=%b, want all 0",
                         i, bus.out_sign, bus.out_exp, bus.out_frac, flags());
            end
        end
        bus.in_valid = 1'b0;
        rst          = 1'b0;
    endtask

    task automatic test_decode();
        vec_t v [10];
        v[0] = '{21'h07F000, 1'b0, 9'h000, 13'h1000, 4'b0000};  // 1.0
        v[1] = '{21'h180400, 1'b1, 9'h001, 13'h1400, 4'b0000};  // -2.5
        v[2] = '{21'h0FF000, 1'b0, 9'h080, 13'h1000, 4'b0100};  // +inf
        v[3] = '{21'h0FF001, 1'b0, 9'h080, 13'h1001, 4'b0010};  // nan
        v[4] = '{21'h100000, 1'b1, 9'h182, 13'h0000, 4'b1000};  // -0
        v[5] = '{21'h000000, 1'b0, 9'h182, 13'h0000, 4'b1000};  // +0
        v[6] = '{21'h001000, 1'b0, 9'h182, 13'h1000, 4'b0000};  // smallest normal
        v[7] = '{21'h0FEFFF, 1'b0, 9'h07F, 13'h1FFF, 4'b0000};  // largest normal
`ifdef FP_UNPACK_DENORM_EN
        v[8] = '{21'h000001, 1'b0, 9'h182, 13'h0001, 4'b0001};
        v[9] = '{21'h100FFF, 1'b1, 9'h182, 13'h0FFF, 4'b0001};
`else
        v[8] = '{21'h000001, 1'b0, 9'h182, 13'h0000, 4'b1000};
        v[9] = '{21'h100FFF, 1'b1, 9'h182, 13'h0000, 4'b1000};
`endif
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            bus.in_valid  = 1'b1;
            bus.in_data   = v[i].din;
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_sign !== v[i].s) begin
                n_fail++;
                $display("FAIL decode_vs[%h]: valid=%b sign=%b, want 1 %b", v[i].din, bus.out_valid, bus.out_sign, v[i].s);
            end
            n_checks++;
            if (bus.out_exp !== v[i].e || bus.out_frac !== v[i].f) begin
                n_fail++;
                $display("FAIL decode_ef[%h]: exp=%h frac=%h, want %h %h", v[i].din, bus.out_exp, bus.out_frac, v[i].e, v[i].f);
            end
            n_checks++;
            if (flags() !== v[i].fl) begin
                n_fail++;
                $display("FAIL decode_flags[%h]: flags=%b, want %b", v[i].din, flags(), v[i].fl);
            end
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pop_no_push: out_valid=%b, want 0", bus.out_valid);
        end
    endtask

    task automatic test_backpressure();
        int p = 0;
        int c = 0;
        int cyc = 0;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = mk_word(0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_checks++;
                if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                    bus.out_frac !== {1'b1, 12'(1)} || bus.out_exp !== 9'(100 - 127)) begin
                    n_fail++;
                    $display("FAIL stall cyc%0d: valid=%b in_ready=%b exp=%h frac=%h, want 1 0 %h 1001",
                             i, bus.out_valid, bus.in_ready, bus.out_exp, bus.out_frac, 9'(100 - 127));
                end
            end
            if (bus.in_valid && bus.in_ready) p++;
            @(posedge clk); #1;
            bus.in_data = mk_word(p);
        end
        bus.out_ready = 1'b1;
        while (c < 8 && cyc < 40) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                n_checks++;
                if (bus.out_exp !== 9'(100 + c - 127) || bus.out_frac !== {1'b1, 12'(c * 3 + 1)}) begin
                    n_fail++;
                    $display("FAIL bp_order #%0d: exp=%h frac=%h, want %h %h",
                             c, bus.out_exp, bus.out_frac, 9'(100 + c - 127), {1'b1, 12'(c * 3 + 1)});
                end
                c++;
            end
            if (bus.in_valid && bus.in_ready) p++;
            @(posedge clk); #1;
            bus.in_valid = (p < 8);
            bus.in_data  = mk_word(p);
            cyc++;
        end
        n_checks++;
        if (c != 8 || p != 8) begin
            n_fail++;
            $display("FAIL bp_count: received=%0d sent=%0d, want 8 8", c, p);
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int p = 0;
        int c = 0;
        int cyc = 0;
        bit seen = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = mk_word(20);
        while (c < 10 && cyc < 40) begin
            @(negedge clk);
            if (seen && !bus.out_valid) begin
                n_checks++;
                n_fail++;
                $display("FAIL b2b_bubble at output %0d: out_valid=%b, want 1", c, bus.out_valid);
            end
            if (bus.out_valid) begin
                seen = 1'b1;
                n_checks++;
                if (bus.out_exp !== 9'(120 + c - 127) || bus.out_frac !== {1'b1, 12'((20 + c) * 3 + 1)}) begin
                    n_fail++;
                    $display("FAIL b2b_order #%0d: exp=%h frac=%h, want %h %h",
                             c, bus.out_exp, bus.out_frac, 9'(120 + c - 127), {1'b1, 12'((20 + c) * 3 + 1)});
                end
                c++;
            end
            if (bus.in_valid && bus.in_ready) p++;
            @(posedge clk); #1;
            bus.in_valid = (p < 10);
            bus.in_data  = mk_word(20 + p);
            cyc++;
        end
        n_checks++;
        if (c != 10 || cyc != 11) begin
            n_fail++;
            $display("FAIL b2b_rate: outputs=%0d cycles=%0d, want 10 11", c, cyc);
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_data = mk_word(40 + i);
            @(posedge clk); #1;
        end
        n_checks++;
        if (bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre: out_valid=%b, want 1", bus.out_valid);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst: out_valid=%b in_ready=%b, want 0 0", bus.out_valid, bus.in_ready);
        end
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_post: out_valid=%b in_ready=%b, want 0 1", bus.out_valid, bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 21'h180400;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_sign !== 1'b1 || bus.out_exp !== 9'h001 || bus.out_frac !== 13'h1400) begin
            n_fail++;
            $display("FAIL midrst_recover: valid=%b sign=%b exp=%h frac=%h, want 1 1 001 1400",
                     bus.out_valid, bus.out_sign, bus.out_exp, bus.out_frac);
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_decode();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
